// File: rtl/reglk_access_ctrl.sv
// Register-lock bank sequencer: initialises every lock word after reset, then
// serialises requester accesses round-robin under a write mask and sticky seal.
module reglk_access_ctrl #(
  parameter int              NREQ     = 3,
  parameter int              NENTRY   = 6,
  parameter logic [31:0]     INIT_VAL = 32'h0,
  parameter logic [NREQ-1:0] WR_MASK  = NREQ'(1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      we_i,
  input  logic [3*NREQ-1:0]    addr_i,
  input  logic [32*NREQ-1:0]   wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  input  logic                 seal_i,
  input  logic                 reinit_i,
  output logic                 bank_en_o,
  output logic                 bank_we_o,
  output logic [2:0]           bank_addr_o,
  output logic [31:0]          bank_wdata_o,
  input  logic [31:0]          bank_rdata_i,
  output logic                 busy_o,
  output logic                 sealed_o
);

  localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] IDX_LAST = 3'(NENTRY - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ARB,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  win_q, win_d;
  logic           we_q, we_d;
  logic [2:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           sealed_q, sealed_d;

  // Per-requester payload views so the winner can be selected by index.
  logic [2:0]  addr_arr  [NREQ];
  logic [31:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[3*g +: 3];
    assign wdata_arr[g] = wdata_i[32*g +: 32];
  end

  // Round-robin search: first requester after the previous winner, wrapping.
  logic          rr_found;
  logic [IW-1:0] rr_win;
  int            rr_cand;

  always_comb begin
    rr_found = 1'b0;
    rr_win   = last_q;
    rr_cand  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_cand = int'(last_q) + i;
      if (rr_cand >= NREQ) rr_cand = rr_cand - NREQ;
      if (!rr_found && req_i[IW'(rr_cand)]) begin
        rr_found = 1'b1;
        rr_win   = IW'(rr_cand);
      end
    end
  end

  logic acc_illegal;
  logic acc_blocked;

  assign acc_illegal = (int'(addr_q) >= NENTRY);
  assign acc_blocked = we_q && (sealed_q || !WR_MASK[win_q]);
  assign sealed_d    = sealed_q | seal_i;

  always_comb begin
    // NOTE: every next-state value and output gets a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    gnt_o        = '0;
    rsp_valid_o  = '0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;
    bank_en_o    = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;

    unique case (state_q)
      ST_INIT: begin
        // Initialisation writes ignore both the seal and the write mask.
        bank_en_o    = 1'b1;
        bank_we_o    = 1'b1;
        bank_addr_o  = idx_q;
        bank_wdata_o = INIT_VAL;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_ARB;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      ST_ARB: begin
        if (reinit_i && !sealed_q) begin
          idx_d   = '0;
          state_d = ST_INIT;
        end else if (rr_found) begin
          win_d   = rr_win;
          we_d    = we_i[rr_win];
          addr_d  = addr_arr[rr_win];
          wdata_d = wdata_arr[rr_win];
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        gnt_o[win_q] = 1'b1;
        err_d        = acc_illegal || acc_blocked;
        rdata_d      = '0;
        if (!(acc_illegal || acc_blocked)) begin
          bank_en_o    = 1'b1;
          bank_we_o    = we_q;
          bank_addr_o  = addr_q;
          bank_wdata_o = wdata_q;
          if (!we_q) rdata_d = bank_rdata_i;
        end
        last_d  = win_q;
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid_o[win_q] = 1'b1;
        rsp_rdata_o        = rdata_q;
        rsp_err_o          = err_q;
        state_d            = ST_ARB;
      end

      default: state_d = ST_INIT;
    endcase
  end

  assign busy_o   = (state_q == ST_INIT);
  assign sealed_o = sealed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the transaction payload registers are reset as well, so no
      // X can reach the response outputs after an aborted access.
      state_q  <= ST_INIT;
      idx_q    <= '0;
      last_q   <= IW'(NREQ - 1);
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sealed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values regardless of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sealed_q <= sealed_d;
    end
  end

endmodule

// File: tb/tb_reglk_access_ctrl.sv
// Bench for reglk_access_ctrl: a cycle-timeline scoreboard of the lock bank
// checked every cycle, plus directed transactions with literal expectations.
module tb_reglk_access_ctrl;

  localparam int              NREQ     = 3;
  localparam int              NENTRY   = 6;
  localparam logic [31:0]     INIT_VAL = 32'h0;
  localparam logic [NREQ-1:0] WR_MASK  = 3'b001;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req, we;
  logic [3*NREQ-1:0]   addr;
  logic [32*NREQ-1:0]  wdata;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                seal, reinit;
  logic                bank_en, bank_we;
  logic [2:0]          bank_addr;
  logic [31:0]         bank_wdata, bank_rdata;
  logic                busy, sealed;

  always #5 clk = ~clk;

  reglk_access_ctrl #(
    .NREQ(NREQ), .NENTRY(NENTRY), .INIT_VAL(INIT_VAL), .WR_MASK(WR_MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .seal_i(seal),
    .reinit_i(reinit), .bank_en_o(bank_en), .bank_we_o(bank_we),
    .bank_addr_o(bank_addr), .bank_wdata_o(bank_wdata),
    .bank_rdata_i(bank_rdata), .busy_o(busy), .sealed_o(sealed)
  );

  // The physical lock bank the controller drives.
  logic [31:0] bank_mem [NENTRY];
  initial for (int i = 0; i < NENTRY; i++) bank_mem[i] = 32'h0;
  always @(posedge clk)
    if (bank_en && bank_we && int'(bank_addr) < NENTRY) bank_mem[bank_addr] <= bank_wdata;
  assign bank_rdata = (int'(bank_addr) < NENTRY) ? bank_mem[bank_addr] : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a timeline of bank events ----------
  typedef struct {
    int          g;       // cycle in which the grant is expected
    int          who;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } txn_t;

  logic [31:0] m_mem [NENTRY];
  bit          m_sealed;
  int          m_last, cyc, init_start, free_at;
  txn_t        m_tx;

  function automatic void model_reset();
    cyc        = 0;
    init_start = 0;
    free_at    = NENTRY;
    m_sealed   = 1'b0;
    m_last     = NREQ - 1;
    m_tx.g     = -10;
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic bit in_init(input int c);
    return c >= init_start && c < init_start + NENTRY;
  endfunction

  // Advance the timeline with the inputs present at each active edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      int w;
      if (in_init(cyc)) m_mem[cyc - init_start] = INIT_VAL;
      if (cyc == m_tx.g) begin
        m_last = m_tx.who;
        if (m_tx.we && !m_tx.err) m_mem[m_tx.addr] = m_tx.wdata;
      end
      if (cyc >= free_at) begin
        if (reinit && !m_sealed) begin
          init_start = cyc + 1;
          free_at    = cyc + 1 + NENTRY;
        end else if (req != '0) begin
          w          = rr_pick(m_last, req);
          m_tx.g     = cyc + 1;
          m_tx.who   = w;
          m_tx.we    = we[w];
          m_tx.addr  = int'(addr[3*w +: 3]);
          m_tx.wdata = wdata[32*w +: 32];
          free_at    = cyc + 3;
        end
      end
      if (seal) m_sealed = 1'b1;
      cyc++;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] e_gnt, e_rv;
    logic [31:0]     e_rdata, e_waddr, e_wdata;
    logic            e_err, e_en, e_we, e_busy;
    if (rst_n !== 1'b1) model_reset();
    e_gnt = '0; e_rv = '0; e_rdata = '0; e_err = 1'b0;
    e_en = 1'b0; e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    e_busy = in_init(cyc);
    if (e_busy) begin
      e_en = 1'b1; e_we = 1'b1; e_waddr = 32'(cyc - init_start); e_wdata = INIT_VAL;
    end
    if (cyc == m_tx.g) begin
      e_gnt[m_tx.who] = 1'b1;
      m_tx.err = (m_tx.addr >= NENTRY) || (m_tx.we && (m_sealed || !WR_MASK[m_tx.who]));
      m_tx.rdata = (!m_tx.err && !m_tx.we) ? m_mem[m_tx.addr] : 32'h0;
      if (!m_tx.err) begin
        e_en = 1'b1; e_we = m_tx.we; e_waddr = 32'(m_tx.addr); e_wdata = m_tx.wdata;
      end
    end
    if (cyc == m_tx.g + 1) begin
      e_rv[m_tx.who] = 1'b1; e_rdata = m_tx.rdata; e_err = m_tx.err;
    end
    check("m_gnt", 32'(gnt), 32'(e_gnt));
    check("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
    check("m_rsp_rdata", rsp_rdata, e_rdata);
    check("m_rsp_err", 32'(rsp_err), 32'(e_err));
    check("m_bank_en", 32'(bank_en), 32'(e_en));
    check("m_bank_we", 32'(bank_we), 32'(e_we));
    if (e_en) begin
      check("m_bank_addr", 32'(bank_addr), e_waddr);
      check("m_bank_wdata", bank_wdata, e_wdata);
    end
    check("m_busy", 32'(busy), 32'(e_busy));
    check("m_sealed", 32'(sealed), 32'(m_sealed));
  end

  // ---------------- directed stimulus ----------------
  task automatic do_txn(input int r, input bit w, input int a, input logic [31:0] d,
                        input bit seal_at_gnt, output logic [1:0] strobe,
                        output logic [31:0] rd, output bit er, output bit rv);
    bit got = 1'b0;
    @(posedge clk); #1;
    req[r] = 1'b1; we[r] = w; addr[3*r +: 3] = 3'(a); wdata[32*r +: 32] = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[r]) got = 1'b1;
    end
    check("txn_gnt_timeout", 32'(got), 32'd1);
    strobe = {bank_en, bank_we};
    if (seal_at_gnt) begin #1 seal = 1'b1; end
    @(posedge clk); #1;
    req[r] = 1'b0; seal = 1'b0;
    @(negedge clk);
    rv = rsp_valid[r]; rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic pulse_reinit_count_busy(output int cnt);
    cnt = 0;
    @(posedge clk); #1 reinit = 1'b1;
    @(posedge clk); #1 reinit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [1:0]  strobe;
    logic [31:0] rd;
    bit          er, rv, got;
    int          order [4];
    int          t_g   [4];
    int          n, cnt, last_g;

    req = '0; we = '0; addr = '0; wdata = '0; seal = 1'b0; reinit = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release: six INIT writes, then ARB.
    for (int k = 0; k < NENTRY; k++) begin
      @(negedge clk);
      check("init_busy", 32'(busy), 32'd1);
      check("init_addr", 32'(bank_addr), 32'(k));
      check("init_strobe", 32'({bank_en, bank_we}), 32'd3);
    end
    @(negedge clk);
    check("init_done_busy", 32'(busy), 32'd0);

    // Three continuous requesters: grants 0,1,2,0 every 3 cycles.
    for (int i = 0; i < 4; i++) begin order[i] = -1; t_g[i] = -100; end
    @(posedge clk); #1;
    req = 3'b111; we = 3'b000; addr = {3'd1, 3'd1, 3'd1};
    n = 0; last_g = -1;
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (last_g >= 0) begin
        check("rr_rsp_after_gnt", 32'(rsp_valid), 32'(1 << last_g));
        last_g = -1;
      end
      if (gnt != '0) begin
        order[n] = oh_idx(gnt); t_g[n] = k; last_g = order[n]; n++;
      end
    end
    @(posedge clk); #1 req = '0;
    check("rr_count", 32'(n), 32'd4);
    check("rr_order0", 32'(order[0]), 32'd0);
    check("rr_order1", 32'(order[1]), 32'd1);
    check("rr_order2", 32'(order[2]), 32'd2);
    check("rr_order3", 32'(order[3]), 32'd0);
    for (int i = 0; i < 3; i++) check("rr_spacing", 32'(t_g[i+1] - t_g[i]), 32'd3);

    // Write by req0 then read back by req1.
    do_txn(0, 1'b1, 2, 32'hA5A5_0001, 1'b0, strobe, rd, er, rv);
    check("wr_strobe", 32'(strobe), 32'd3);
    check("wr_err", 32'(er), 32'd0);
    check("wr_rv", 32'(rv), 32'd1);
    do_txn(1, 1'b0, 2, 32'h0, 1'b0, strobe, rd, er, rv);
    check("rd_strobe", 32'(strobe), 32'd2);
    check("rd_data", rd, 32'hA5A5_0001);
    check("rd_err", 32'(er), 32'd0);

    // Masked write and illegal address.
    do_txn(1, 1'b1, 3, 32'h1234_5678, 1'b0, strobe, rd, er, rv);
    check("mask_strobe", 32'(strobe), 32'd0);
    check("mask_err", 32'(er), 32'd1);
    do_txn(0, 1'b0, 6, 32'h0, 1'b0, strobe, rd, er, rv);
    check("illegal_strobe", 32'(strobe), 32'd0);
    check("illegal_err", 32'(er), 32'd1);
    check("illegal_rdata", rd, 32'h0);

    // Re-initialisation before the seal.
    pulse_reinit_count_busy(cnt);
    check("reinit_busy_cycles", 32'(cnt), 32'd6);
    do_txn(1, 1'b0, 2, 32'h0, 1'b0, strobe, rd, er, rv);
    check("reinit_cleared", rd, INIT_VAL);

    // Seal raised during a write's ACCESS cycle does not block that write.
    do_txn(0, 1'b1, 4, 32'hCAFE_0004, 1'b1, strobe, rd, er, rv);
    check("seal_same_cycle_strobe", 32'(strobe), 32'd3);
    check("seal_same_cycle_err", 32'(er), 32'd0);
    check("sealed_set", 32'(sealed), 32'd1);
    do_txn(1, 1'b0, 4, 32'h0, 1'b0, strobe, rd, er, rv);
    check("sealed_read", rd, 32'hCAFE_0004);
    do_txn(0, 1'b1, 5, 32'h5555_5555, 1'b0, strobe, rd, er, rv);
    check("sealed_wr_strobe", 32'(strobe), 32'd0);
    check("sealed_wr_err", 32'(er), 32'd1);
    pulse_reinit_count_busy(cnt);
    check("sealed_reinit_ignored", 32'(cnt), 32'd0);

    // Reset asserted during ACCESS aborts the transaction.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[2:0] = 3'd4;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[0]) got = 1'b1;
    end
    check("abort_gnt_timeout", 32'(got), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_sealed", 32'(sealed), 32'd0);
    check("abort_addr", 32'(bank_addr), 32'd0);
    req = '0;
    @(negedge clk);
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < NENTRY; k++) begin
      @(negedge clk);
      check("reinit_rst_addr", 32'(bank_addr), 32'(k));
    end
    @(negedge clk);
    check("reinit_rst_done", 32'(busy), 32'd0);
    do_txn(0, 1'b1, 4, 32'h0000_0077, 1'b0, strobe, rd, er, rv);
    check("post_reset_wr_err", 32'(er), 32'd0);
    do_txn(2, 1'b0, 4, 32'h0, 1'b0, strobe, rd, er, rv);
    check("post_reset_rd", rd, 32'h0000_0077);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reglk_access_ctrl.md
# reglk_access_ctrl

Sequencer and round-robin arbiter for the register-lock bank (6 × 32-bit lock words). It sits between NREQ requesters (firmware AXI-lite shim, debug module, boot ROM) and the bank's single read/write port. After reset it initialises every entry, then serialises requester accesses. It enforces a per-requester write mask and a sticky seal that freezes the bank against further writes until reset.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- NENTRY, 6, lock words in the bank; addr ≥ NENTRY is illegal
- INIT_VAL, 32'h0, value written to every entry during INIT
- WR_MASK, 3'b001 (NREQ bits), bit r=1 lets requester r write

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  NREQ  request per requester; held with payload until gnt
- we_i  in  NREQ  1=write, 0=read
- addr_i  in  3*NREQ  entry index, requester r at [3r+:3]
- wdata_i  in  32*NREQ  write data, requester r at [32r+:32]
- gnt_o  out  NREQ  one-hot, 1-cycle pulse in ACCESS
- rsp_valid_o  out  NREQ  one-hot, 1-cycle pulse in RESP
- rsp_rdata_o  out  32  read data (0 for writes and errors)
- rsp_err_o  out  1  valid with rsp_valid_o
- seal_i  in  1  level; sets sticky seal
- reinit_i  in  1  request re-initialisation
- bank_en_o, bank_we_o  out  1 each  bank strobe / write enable
- bank_addr_o  out  3; bank_wdata_o  out  32
- bank_rdata_i  in  32  combinational read data for bank_addr_o
- busy_o  out  1  high while in INIT
- sealed_o  out  1  sticky seal state

## Operation
- States: INIT, ARB, ACCESS, RESP. Reset state INIT, idx=0.
- INIT: bank_en_o=bank_we_o=1, bank_addr_o=idx, bank_wdata_o=INIT_VAL; idx increments each cycle; after idx=NENTRY-1 → ARB. Requests are ignored. INIT writes bypass seal and WR_MASK.
- ARB: if reinit_i && !sealed_q → INIT (idx=0); reinit_i has priority over requests. Otherwise, if any req_i, pick the winner by round-robin starting at last+1 mod NREQ, register winner/we/addr/wdata, and → ACCESS. No request → stay.
- ACCESS: gnt_o[winner]=1.
  - Illegal address (≥NENTRY): err=1, no bank strobe.
  - Write with sealed_q=1 or WR_MASK[winner]=0: err=1, no bank strobe.
  - Otherwise: bank_en_o=1, bank_we_o=we, addr and wdata driven. For reads, bank_rdata_i is captured.
  - Update last=winner; → RESP.
- RESP: rsp_valid_o[winner]=1 with rsp_rdata_o (captured read data, or 0) and rsp_err_o; → ARB.
- Seal: sealed_q is set on any clock edge with seal_i=1 and cleared only by reset. sealed_o=sealed_q.
- reinit_i arriving outside ARB is not latched. It is acted on only if it is still high in ARB.
- Round-robin pointer `last` resets to NREQ-1, so requester 0 wins first.

## Timing
- Reset (async): state=INIT, idx=0, last=NREQ-1, sealed_q=0.
- During reset: all outputs 0, except busy_o=1 and bank_en_o=bank_we_o=1 (INIT decode). The first INIT write completes on the first edge after rst_ni rises.
- INIT lasts NENTRY cycles. busy_o falls the cycle ARB is entered.
- Transaction: req sampled in ARB (cycle 0), gnt_o and bank access in cycle 1, rsp_valid_o in cycle 2. Next ARB is cycle 3, so a back-to-back requester is serviced every 3 cycles.
- req_i/payload changes after gnt_o are not seen until the next ARB.
- seal_i asserted in the same cycle as the ACCESS of a write does not block that write, because ACCESS uses the registered sealed_q.
- Reset asserted mid-transaction: the access is aborted, no rsp is issued, and INIT reruns.

## Test plan
- Reset release: 6 consecutive bank writes of INIT_VAL to addr 0..5 with busy_o=1, then busy_o=0 on cycle 7.
- Requesters 0,1,2 all request continuously → grants in order 0,1,2,0, gnt_o pulses spaced 3 cycles apart, each rsp exactly 1 cycle after its gnt.
- Req0 writes 32'hA5A5_0001 to addr 2, then req1 reads addr 2 → bank strobe with we=1 then we=0; rsp_rdata_o=32'hA5A5_0001, err=0.
- Req1 writes (WR_MASK bit 0) → no bank strobe, rsp_err_o=1. Req0 reads addr 6 → no strobe, err=1, rdata=0.
- Pulse seal_i, then req0 writes → err=1, no strobe. reinit_i in ARB is ignored while sealed. Before seal, reinit_i reruns the 6-cycle INIT.
- Assert rst_ni low during ACCESS → outputs reset immediately, no rsp_valid_o, INIT restarts at idx 0, sealed_o=0.
